// File: rtl/cvtiw_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cvtiw_pipe
// Purpose  : Three-stage pipelined integer to IEEE-754 float converter with
//            valid/ready handshake, per-beat signedness and rounding mode.
// Revision : 1.0 - initial release
// ============================================================================
module cvtiw_pipe #(
    parameter int INTn = 32,
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    localparam int LAST_RA = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INTn-1:0]        w,
    input  logic                   is_signed,
    input  logic [LAST_RA:0]       ra,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NEXP+NSIG:0]     s,
    output logic                   inexact,
    output logic                   overflow
);

    // Rounding-attribute bit positions
    localparam int c_RA_RNE = 0;
    localparam int c_RA_RTZ = 1;
    localparam int c_RA_RTP = 2;
    localparam int c_RA_RTN = 3;
    localparam int c_RA_RNA = 4;

    localparam int c_LZW = $clog2(INTn + 1);
    localparam int c_XW  = ((NEXP > c_LZW) ? NEXP : c_LZW) + 2;
    localparam int c_EXW = INTn + NSIG + 1;
    localparam logic [c_XW-1:0] c_BIAS = c_XW'((1 << (NEXP - 1)) - 1);

    logic                 w_load1, w_load2, w_load3;
    logic                 r_v1, r_v2, r_v3;
    logic                 r_sign1, r_sign2;
    logic [INTn-1:0]      r_mag1;
    logic [INTn-2:0]      r_frac2;
    logic [c_XW-1:0]      r_e2;
    logic                 r_zero2;
    logic [LAST_RA:0]     r_ra1, r_ra2;

    logic                 w_sign_in;
    logic [INTn-1:0]      w_mag_in;
    logic [c_LZW-1:0]     w_lzc;
    logic [INTn-2:0]      w_frac;
    logic [c_EXW-1:0]     w_ext;
    logic [NSIG-1:0]      w_sig;
    logic                 w_g, w_st, w_up, w_ovf_inf, w_ovf;
    logic [NSIG:0]        w_sig_r;
    logic [c_XW-1:0]      w_e_r;
    logic [NEXP-1:0]      w_exp_fld;
    logic [NEXP+NSIG:0]   w_s;
    logic                 w_inx;

    // Each stage may load when empty or when its content moves on this cycle
    assign w_load3   = ~r_v3 | out_ready;
    assign w_load2   = ~r_v2 | w_load3;
    assign w_load1   = ~r_v1 | w_load2;
    assign in_ready  = w_load1 & ~rst;
    assign out_valid = r_v3;

    assign w_sign_in = is_signed & w[INTn-1];
    assign w_mag_in  = w_sign_in ? -w : w;

    always_comb begin
        w_lzc = c_LZW'(INTn);
        for (int i = 0; i < INTn; i++) begin
            if (r_mag1[i]) w_lzc = c_LZW'(INTn - 1 - i);
        end
    end

    // Normalised MSB is implicit, so only the bits below it are kept
    assign w_frac = (INTn-1)'(r_mag1 << w_lzc);

    assign w_ext   = {r_frac2, {(NSIG + 2){1'b0}}};
    assign w_sig   = w_ext[c_EXW-1 -: NSIG];
    assign w_g     = w_ext[c_EXW-1-NSIG];
    assign w_st    = |w_ext[c_EXW-2-NSIG:0];

    always_comb begin
        w_up      = w_g & (w_st | w_sig[0]);
        w_ovf_inf = 1'b1;
        case (r_ra2)
            (LAST_RA+1)'(1 << c_RA_RNA): w_up = w_g;
            (LAST_RA+1)'(1 << c_RA_RTZ): begin
                w_up      = 1'b0;
                w_ovf_inf = 1'b0;
            end
            (LAST_RA+1)'(1 << c_RA_RTP): begin
                w_up      = ~r_sign2 & (w_g | w_st);
                w_ovf_inf = ~r_sign2;
            end
            (LAST_RA+1)'(1 << c_RA_RTN): begin
                w_up      = r_sign2 & (w_g | w_st);
                w_ovf_inf = r_sign2;
            end
            default: ;
        endcase
    end

    assign w_sig_r   = {1'b0, w_sig} + (NSIG+1)'(w_up);
    assign w_e_r     = r_e2 + c_XW'(w_sig_r[NSIG]);
    assign w_ovf     = w_e_r > c_BIAS;
    assign w_exp_fld = NEXP'(w_e_r + c_BIAS);

    always_comb begin
        w_s   = {r_sign2, w_exp_fld, w_sig_r[NSIG-1:0]};
        w_inx = w_g | w_st;
        if (r_zero2) begin
            w_s   = '0;
            w_inx = 1'b0;
        end else if (w_ovf) begin
            w_inx = 1'b1;
            if (w_ovf_inf) w_s = {r_sign2, {NEXP{1'b1}}, {NSIG{1'b0}}};
            else           w_s = {r_sign2, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            s        <= '0;
            inexact  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (w_load1) begin
                r_v1    <= in_valid;
                r_sign1 <= w_sign_in;
                r_mag1  <= w_mag_in;
                r_ra1   <= ra;
            end
            if (w_load2) begin
                r_v2    <= r_v1;
                r_sign2 <= r_sign1;
                r_frac2 <= w_frac;
                r_e2    <= c_XW'(INTn - 1) - c_XW'(w_lzc);
                r_zero2 <= (r_mag1 == '0);
                r_ra2   <= r_ra1;
            end
            if (w_load3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    s        <= w_s;
                    inexact  <= w_inx;
                    overflow <= w_ovf & ~r_zero2;
                end
            end
        end
    end

endmodule
`default_nettype wire
